// File: rtl/bus_master_arbiter_if.sv
// Requester and bus-side signals of the two-master basil bus arbiter.
// The arbiter uses the slave view; requesters and bus models use the master view.
interface bus_master_arbiter_if #(
    parameter int ABUSWIDTH = 32
);
    logic                 M0_WE, M0_RE;
    logic [ABUSWIDTH-1:0] M0_ADD;
    logic [7:0]           M0_WD, M0_RD;
    logic                 M0_ACK, M0_GNT;

    logic                 M1_WE, M1_RE;
    logic [ABUSWIDTH-1:0] M1_ADD;
    logic [7:0]           M1_WD, M1_RD;
    logic                 M1_ACK, M1_GNT;

    logic                 BUS_WR, BUS_RD;
    logic [ABUSWIDTH-1:0] BUS_ADD;

    modport slave (
        input  M0_WE, M0_RE, M0_ADD, M0_WD,
        input  M1_WE, M1_RE, M1_ADD, M1_WD,
        output M0_RD, M0_ACK, M0_GNT,
        output M1_RD, M1_ACK, M1_GNT,
        output BUS_WR, BUS_RD, BUS_ADD
    );

    modport master (
        output M0_WE, M0_RE, M0_ADD, M0_WD,
        output M1_WE, M1_RE, M1_ADD, M1_WD,
        input  M0_RD, M0_ACK, M0_GNT,
        input  M1_RD, M1_ACK, M1_GNT,
        input  BUS_WR, BUS_RD, BUS_ADD
    );
endinterface

// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter sharing one basil bus between two byte-wide requesters.
// Each transaction: IDLE (latch winner) -> ACCESS (strobe) -> WAIT (reads) -> DONE (ACK).
module bus_master_arbiter #(
    parameter int ABUSWIDTH    = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                   BUS_CLK,
    input  logic                   BUS_RST_N,
    bus_master_arbiter_if.slave    bus,
    inout  wire  [7:0]             BUS_DATA
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic                 win_q, win_d;
    logic                 wr_q, wr_d;
    logic [ABUSWIDTH-1:0] add_q, add_d;
    logic [7:0]           wd_q, wd_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [7:0]           rd0_q, rd0_d;
    logic [7:0]           rd1_q, rd1_d;

    logic req0, req1, pick;

    assign req0 = bus.M0_WE | bus.M0_RE;
    assign req1 = bus.M1_WE | bus.M1_RE;
    // On a tie the requester that did not win last time is served.
    assign pick = (req0 & req1) ? ~last_q : req1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        wr_d    = wr_q;
        add_d   = add_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    win_d   = pick;
                    last_d  = pick;
                    add_d   = pick ? bus.M1_ADD : bus.M0_ADD;
                    wd_d    = pick ? bus.M1_WD  : bus.M0_WD;
                    wr_d    = pick ? bus.M1_WE  : bus.M0_WE;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (wr_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = 3'(READ_LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (win_q) rd1_d = BUS_DATA;
                    else       rd0_d = BUS_DATA;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            wr_q    <= 1'b0;
            add_q   <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            wr_q    <= wr_d;
            add_q   <= add_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    logic busy, access, done;
    assign busy   = (state_q != IDLE);
    assign access = (state_q == ACCESS);
    assign done   = (state_q == DONE);

    assign bus.BUS_WR  = access &  wr_q;
    assign bus.BUS_RD  = access & ~wr_q;
    assign bus.BUS_ADD = add_q;
    assign BUS_DATA    = (access & wr_q) ? wd_q : 8'hzz;

    assign bus.M0_GNT = busy & ~win_q;
    assign bus.M1_GNT = busy &  win_q;
    assign bus.M0_ACK = done & ~win_q;
    assign bus.M1_ACK = done &  win_q;
    assign bus.M0_RD  = rd0_q;
    assign bus.M1_RD  = rd1_q;
endmodule

// File: doc/bus_master_arbiter.md
Name: bus_master_arbiter

Overview:
- Shares one basil bus (BUS_WR/BUS_RD/BUS_ADD/BUS_DATA) between two byte-wide requesters, e.g. an RBCP/SiTCP bridge and a local sequencer or USB bridge.
- Each requester issues single-byte read/write transactions and holds them until a one-cycle ACK.
- Arbitration is round-robin. The block sequences each bus cycle: one strobe cycle, then a fixed read-latency wait, then read-data capture and acknowledge.
- Sits between the master-side bridges and the bus-decoded peripheral modules.

Parameters:
- ABUSWIDTH, 32, width of requester and bus address.
- READ_LATENCY, 1, cycles from the BUS_RD strobe to valid BUS_DATA. Legal range 1..7.

Ports:
- BUS_CLK  input  1  bus clock; all logic on its rising edge
- BUS_RST_N  input  1  asynchronous active-low reset
- M0_WE  input  1  requester 0 write request (level, held until M0_ACK)
- M0_RE  input  1  requester 0 read request (level, held until M0_ACK)
- M0_ADD  input  ABUSWIDTH  requester 0 address
- M0_WD  input  8  requester 0 write data
- M0_RD  output  8  requester 0 read data
- M0_ACK  output  1  requester 0 done pulse
- M0_GNT  output  1  requester 0 owns the bus
- M1_WE, M1_RE, M1_ADD, M1_WD, M1_RD, M1_ACK, M1_GNT: same as M0_* for requester 1
- BUS_WR  output  1  bus write strobe
- BUS_RD  output  1  bus read strobe
- BUS_ADD  output  ABUSWIDTH  bus address
- BUS_DATA  inout  8  bus data

Behaviour:
- One clock (BUS_CLK); reset is asynchronous and active-low (BUS_RST_N). Assertion immediately clears all state; release is synchronous to BUS_CLK.
- Reset values:
  - state = IDLE; last_grant = 1, so M0 wins the first tie.
  - Mx_GNT = Mx_ACK = BUS_WR = BUS_RD = 0.
  - BUS_ADD = 0, Mx_RD = 0, BUS_DATA = Z.
- Request: Mx_REQ = Mx_WE | Mx_RE. If WE and RE are both high, the transaction is a write.
- State machine: IDLE -> ACCESS -> (WAIT, reads only) -> DONE -> IDLE.
  - IDLE: if any REQ is high, select a winner. If only one requests, it wins. If both request, the one not equal to last_grant wins. Latch the winner's address, write data and op. Set that GNT, update last_grant, go to ACCESS.
  - ACCESS (1 cycle): BUS_WR or BUS_RD = 1 and BUS_ADD = latched address. For writes, BUS_DATA = latched WD; otherwise Z. Writes go to DONE; reads go to WAIT with counter = READ_LATENCY.
  - WAIT: decrement the counter. In the cycle the counter reaches 1, register BUS_DATA into the winner's Mx_RD, then go to DONE.
  - DONE (1 cycle): winner's ACK = 1; GNT drops at the end of the cycle; go to IDLE.
- Latency, with the request first seen in IDLE at cycle t:
  - Write: strobe at t+1, ACK at t+2.
  - Read: strobe at t+1, data sampled at t+1+READ_LATENCY, ACK at t+2+READ_LATENCY.
- Throughput: the minimum gap between strobes is 3 cycles for writes, because IDLE is always visited.
- Handshake:
  - Requesters keep WE/RE/ADD/WD stable from request until ACK. Changes after the latch cycle are ignored.
  - A requester must drop REQ in the cycle after ACK, or present a new request then. REQ high in IDLE is always a new transaction.
- Read data: Mx_RD holds the last read value for that requester. It is unchanged by writes and by the other requester's transactions.
- BUS_ADD holds the last latched address outside ACCESS.
- BUS_DATA is driven only in ACCESS of a write; it is Z in every other state, under reset, and in the cycle right after reset.
- GNT is one-hot or zero, never both high. ACK only goes to the current winner.
- Fairness: with both requesters continuously requesting, grants strictly alternate. No requester waits more than one full transaction of the other.

Test Plan:
- Reset and idle: reset asserted mid-read (state WAIT), BUS_RST_N=0 asynchronously -> same cycle: BUS_RD=0, BUS_DATA=Z, GNT/ACK=0. After release, a new M0 write completes normally.
- Single write: M0_WE=1, M0_ADD=0x10, M0_WD=0xA5 at cycle t -> BUS_WR=1 with BUS_ADD=0x10 and BUS_DATA=0xA5 at t+1 only; M0_ACK=1 at t+2 only; M1_ACK stays 0.
- Single read, READ_LATENCY=1 and 3: bus model returns 0x3C one cycle after BUS_RD at address 0x20, via M1_RE -> BUS_RD at t+1; M1_RD=0x3C with M1_ACK at t+3 (L=1) or t+5 (L=3).
- Contention: M0 and M1 both request writes at the same cycle after reset -> M0 is served first, then M1. Held continuously for 6 transactions -> grant order 0,1,0,1,0,1.
- Write+read conflict and stability: M0 asserts WE and RE together -> exactly one BUS_WR, no BUS_RD. M1 changes M1_ADD during WAIT -> BUS_ADD stays at the latched value.
- Read-data isolation: M0 reads 0x11, then M1 reads 0x22, then M0 writes -> M0_RD stays 0x11 and M1_RD stays 0x22 throughout.
